mem_bridge: RTL
===============

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 16: CPU byte-address width and SRAM address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 req  input  1  CPU access strobe (level), sampled only in IDLE.
REQ-005 we  input  1  1 = write access, 0 = read access; sampled with req.
REQ-006 addr  input  ADDR_W  CPU byte address; addr[0] ignored, word = addr[ADDR_W-1:1].
REQ-007 wdata  input  16  write data; [7:0] low lane, [15:8] high lane.
REQ-008 byte_enable  input  2  lane select; bit0 = low byte, bit1 = high byte; 11 = word.
REQ-009 rdata  output  16  read data, valid when ready=1, held until next read completes.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 sram_addr  output  ADDR_W  SRAM byte address.
REQ-012 sram_dout  output  8  SRAM write data.
REQ-013 sram_din  input  8  SRAM read data; valid the cycle after sram_oe=1 with a given address.
REQ-014 sram_we  output  1  SRAM write strobe, one cycle per byte.
REQ-015 sram_oe  output  1  SRAM read enable, one cycle per byte.

Function
REQ-016 Bridge SHALL convert one 16-bit CPU access into 0-2 byte accesses on an 8-bit synchronous SRAM, little-endian (low lane at even address).
REQ-017 FSM states SHALL be IDLE, LO, HI, CAP, DONE.
REQ-018 In IDLE with req=1, bridge SHALL latch we, addr, wdata, byte_enable into holding registers; later CPU input changes SHALL have no effect until the access finishes.
REQ-019 IDLE exits: be=00 -> DONE; be[0]=1 -> LO; be=10 -> HI.
REQ-020 LO SHALL drive sram_addr={a[ADDR_W-1:1],0}; write: sram_we=1, sram_dout=wdata[7:0]; read: sram_oe=1.
REQ-021 HI SHALL drive sram_addr={a[ADDR_W-1:1],1}; write: sram_we=1, sram_dout=wdata[15:8]; read: sram_oe=1.
REQ-022 From LO: be[1]=1 -> HI; else read -> CAP, write -> DONE.
REQ-023 From HI: read -> CAP; write -> DONE.
REQ-024 The state after a LO read (HI or CAP) SHALL capture sram_din into rdata[7:0]; CAP after a HI read SHALL capture sram_din into rdata[15:8].
REQ-025 CAP SHALL go to DONE; DONE SHALL assert ready=1 for exactly one cycle and return to IDLE.
REQ-026 On read completion, unselected lanes of rdata SHALL be 0.
REQ-027 rdata SHALL remain unchanged by write accesses and by be=00 accesses.
REQ-028 Latency from req sampled in IDLE (cycle 0) to ready: word read 4, byte read 3, word write 3, byte write 2, be=00 1.
REQ-029 Outside LO/HI: sram_we=0, sram_oe=0, sram_addr=0, sram_dout=0; sram_we and sram_oe SHALL never be 1 together.
REQ-030 req SHALL be ignored outside IDLE; if req is still 1 when DONE returns to IDLE, a new access SHALL start, so the CPU drops req in its ready cycle unless it issues back-to-back accesses.
REQ-031 All outputs SHALL be registered or decoded from state/holding registers only; no combinational path from CPU inputs to SRAM outputs.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE and ready=0, sram_we=0, sram_oe=0, sram_addr=0, sram_dout=0, rdata=0, holding registers=0, independent of clk.
REQ-033 Reset asserted mid-access SHALL abort it with no ready pulse; a byte already written stays written; the first req after reset release starts a fresh access.

Verification
REQ-034 Word write addr=0x0010, wdata=0xBEEF, be=11 -> cycle 1: sram_we, addr 0x0010, dout 0xEF; cycle 2: addr 0x0011, dout 0xBE; ready at cycle 3.
REQ-035 Word read addr=0x0011 (addr[0] ignored), SRAM model [0x10]=0x34, [0x11]=0x12 -> sram_oe at cycles 1-2, ready at cycle 4 with rdata=0x1234.
REQ-036 High-byte read be=10 addr=0x0020, [0x21]=0xA5 -> single sram_oe at 0x0021, ready at cycle 3, rdata=0xA500.
REQ-037 be=00 write -> no sram_we/sram_oe, ready at cycle 1, rdata unchanged from prior 0x1234.
REQ-038 Reset pulse during HI of a word write -> sram_we falls without a clk edge, no ready, state IDLE; next word read completes normally in 4 cycles.
REQ-039 req held high across two word reads -> second access starts the cycle after ready; changing addr during first access does not alter its sram_addr.

Source files
------------

// File: rtl/mem_bridge.sv
// 16-bit CPU to 8-bit synchronous SRAM bridge: splits one CPU access into
// 0-2 little-endian byte accesses and reassembles read data.
module mem_bridge #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic [1:0]        byte_enable,
  output logic [15:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_we,
  output logic              sram_oe
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    CAP,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LANE_HI = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [1:0]        be_q;
  logic [7:0]        lo_buf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      lo_buf  <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= byte_enable;
      end
      // Low byte of a word read arrives during HI; park it so rdata only
      // changes once, on entry to DONE, with the whole word.
      if (state == HI && !we_q && be_q[0]) begin
        lo_buf <= sram_din;
      end
      if (state == CAP) begin
        rdata <= {be_q[1] ? sram_din : 8'h00,
                  be_q[0] ? (be_q[1] ? lo_buf : sram_din) : 8'h00};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    sram_we   = 1'b0;
    sram_oe   = 1'b0;
    sram_addr = '0;
    sram_dout = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (byte_enable == 2'b00) begin
            state_nxt = DONE;
          end else if (byte_enable[0]) begin
            state_nxt = LO;
          end else begin
            state_nxt = HI;
          end
        end
      end
      LO: begin
        sram_addr = addr_q & ~LANE_HI;
        sram_we   = we_q;
        sram_oe   = !we_q;
        sram_dout = we_q ? wdata_q[7:0] : 8'h00;
        if (be_q[1]) begin
          state_nxt = HI;
        end else begin
          state_nxt = we_q ? DONE : CAP;
        end
      end
      HI: begin
        sram_addr = addr_q | LANE_HI;
        sram_we   = we_q;
        sram_oe   = !we_q;
        sram_dout = we_q ? wdata_q[15:8] : 8'h00;
        state_nxt = we_q ? DONE : CAP;
      end
      CAP: begin
        state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
